alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 8-bit combinational ALU.
- Captures each accepted ALU result together with its destination register and write-enable into a small in-order buffer, and hands entries to register-file writeback over a valid/ready handshake.
- Owns the architectural flag register (carry, shift), updated per opcode class at acceptance time; downstream branch logic reads the flags.

Parameters:
- DEPTH, 2, buffer entries; legal values 2..8, power of two not required.
- RADDR_W, 3, register-address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ALU result presented this cycle
- in_ready  output  1  stage can accept; equals (count != DEPTH) && !flush
- in_opcode  input  4  opcode that produced the result (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SHL, 0101 SHR, others NOP)
- in_result  input  8  ALU result
- in_carry  input  1  ALU carry flag
- in_shift  input  1  ALU shift-out flag
- in_rd  input  RADDR_W  destination register
- in_wen  input  1  instruction writes a register
- flush  input  1  discard all buffered entries (branch mispredict / exception)
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback consumes head
- out_data  output  8  head result
- out_rd  output  RADDR_W  head destination
- out_wen  output  1  head write-enable
- carry_q  output  1  architectural carry flag
- shift_q  output  1  architectural shift flag
- count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: count=0, out_valid=0, out_data=0, out_rd=0, out_wen=0, carry_q=0, shift_q=0; all buffer storage invalid. Reset overrides flush and any handshake in the same cycle.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. out_* are driven directly from the head entry, so an entry pushed at cycle N is visible at cycle N+1 (latency 1).
- NOP opcodes are buffered like any other entry; in_wen is passed through unchanged.
- When full (count==DEPTH), in_ready=0 even if a pop happens that cycle. No same-cycle push-through-full.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, FIFO order preserved. With count==0, out_valid rises the next cycle. There is no bypass.
- Read and write pointers wrap modulo DEPTH. For non-power-of-two DEPTH the wrap is explicit compare-and-clear.
- Flush: in_ready=0 that cycle. Next cycle count=0, out_valid=0, and pointers are reset to 0. A pop handshaked in the flush cycle still counts as consumed. Flags are not altered by flush.
- Flag update (on push only): ADD/SUB set carry_q<=in_carry, shift_q unchanged. SHL/SHR set shift_q<=in_shift, carry_q unchanged. AND/OR/NOP leave both unchanged. Flags change the cycle after push, independent of downstream stall.
- out_valid never drops without a pop, flush, or reset. out_* stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_WB_ZERO_FLAG_EN.
- Defined:
  - Adds output zero_q (1 bit, reset 0).
  - On push of ADD/SUB/AND/OR/SHL/SHR, zero_q <= (in_result==8'h00). NOP leaves it unchanged. Flush does not affect it.
- Undefined: the port and its register are absent, and all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD..OP_SHR);
  - typedef wb_entry_t {data[7:0], rd, wen};
  - helper functions is_arith(op) and is_shift(op).
- Sub-module wb_fifo (parameterised DEPTH, entry type = wb_entry_t) holds storage, pointers, count and flush.
- alu_wb_stage top holds the handshake glue and the flag register.

Test Plan:
- Reset then idle: count=0, out_valid=0, carry_q=0, shift_q=0. Push ADD result 8'h10, rd=3, wen=1 with out_ready=1 -> next cycle out_valid=1, out_data=8'h10, out_rd=3; one cycle later count=0.
- Flag selectivity: push ADD carry=1, then AND (carry=0, shift=1 on inputs), then SHL shift=1 -> after ADD carry_q=1; after AND carry_q=1, shift_q=0; after SHL shift_q=1, carry_q=1.
- Backpressure: out_ready=0, push 8'hA1 then 8'hA2 (DEPTH=2) -> in_ready=0, count=2, out_data holds 8'hA1. A third in_valid is not accepted. Raise out_ready -> 8'hA1 then 8'hA2 in order.
- Full with simultaneous pop: count=2, out_ready=1, in_valid=1 -> in_ready=0, count becomes 1, pending input accepted the following cycle.
- Flush mid-stream: count=2, carry_q=1, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, carry_q=1, input not consumed. Reset asserted alongside flush -> all outputs 0.
- With ALU_WB_ZERO_FLAG_EN: push SUB result 8'h00 -> zero_q=1; push NOP result 8'h00 after an OR result 8'h05 -> zero_q stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute-to-writeback slice:
// opcode encodings, the buffered writeback entry and opcode-class helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;

  // Default register-address width of the writeback entry.
  localparam int WB_RADDR_W = 3;

  typedef struct packed {
    logic [7:0]            data;
    logic [WB_RADDR_W-1:0] rd;
    logic                  wen;
  } wb_entry_t;

  // ADD/SUB own the carry flag.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // SHL/SHR own the shift-out flag.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // AND/OR touch no carry/shift flag but still produce a real result.
  function automatic logic is_logic(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer: DEPTH entries, explicit pointer wrap so any
// DEPTH in 2..8 works, and a flush that empties it in one cycle.
module wb_fifo
  import alu_pkg::*;
#(
  parameter  int  DEPTH   = 2,
  parameter  type entry_t = wb_entry_t,
  localparam int  CNT_W   = $clog2(DEPTH + 1),
  localparam int  PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           wr_entry,
  input  logic             pop,
  output entry_t           rd_entry,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Head entry drives the outputs directly; no bypass from the write port.
  assign rd_entry = mem[rd_ptr];

  // Entry storage: written on push only.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: storage is reset because the head entry feeds the outputs
      // straight through and those must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; flush returns everything to the empty state.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results for register-file
// writeback over valid/ready and owns the architectural flag register.
// Optional macro ALU_WB_ZERO_FLAG_EN adds a zero flag output (zero_q).
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter  int DEPTH   = 2,
  parameter  int RADDR_W = WB_RADDR_W,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [7:0]         in_result,
  input  logic               in_carry,
  input  logic               in_shift,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wen,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wen,
  output logic               carry_q,
  output logic               shift_q,
`ifdef ALU_WB_ZERO_FLAG_EN
  output logic               zero_q,
`endif
  output logic [CNT_W-1:0]   count
);

  // Entry layout follows the configured register-address width.
  typedef struct packed {
    logic [7:0]         data;
    logic [RADDR_W-1:0] rd;
    logic               wen;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t wr_entry;
  entry_t rd_entry;
  logic   push;
  logic   pop;

  // Full blocks input even when a pop is in progress; flush blocks it too.
  assign in_ready  = (count != FULL_CNT) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry  = '{data: in_result, rd: in_rd, wen: in_wen};
  assign out_data  = rd_entry.data;
  assign out_rd    = rd_entry.rd;
  assign out_wen   = rd_entry.wen;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (rd_entry),
    .count    (count)
  );

  // Flags update at acceptance by opcode class; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      shift_q <= 1'b0;
    end else if (push) begin
      if (is_arith(in_opcode)) carry_q <= in_carry;
      if (is_shift(in_opcode)) shift_q <= in_shift;
    end
  end

`ifdef ALU_WB_ZERO_FLAG_EN
  // Zero flag tracks every real ALU result; NOP leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
    end else if (push && (is_arith(in_opcode) || is_logic(in_opcode) ||
                          is_shift(in_opcode))) begin
      zero_q <= (in_result == 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed-vector bench for alu_wb_stage (DEPTH=2, RADDR_W=3).
module tb_alu_wb_stage;

  localparam int DEPTH   = 2;
  localparam int RADDR_W = 3;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010,
                         OR_ = 4'b0011, SHL = 4'b0100, NOP = 4'b1111;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_opcode = '0;
  logic [7:0]         in_result = '0;
  logic               in_carry = 1'b0;
  logic               in_shift = 1'b0;
  logic [RADDR_W-1:0] in_rd = '0;
  logic               in_wen = 1'b0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [7:0]         out_data;
  logic [RADDR_W-1:0] out_rd;
  logic               out_wen;
  logic               carry_q;
  logic               shift_q;
`ifdef ALU_WB_ZERO_FLAG_EN
  logic               zero_q;
`endif
  logic [CNT_W-1:0]   count;

  int tests = 0;
  int fails = 0;

  alu_wb_stage #(.DEPTH(DEPTH), .RADDR_W(RADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_result (in_result),
    .in_carry  (in_carry),
    .in_shift  (in_shift),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .carry_q   (carry_q),
    .shift_q   (shift_q),
`ifdef ALU_WB_ZERO_FLAG_EN
    .zero_q    (zero_q),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] data,
                       input logic [RADDR_W-1:0] rd, input logic wen,
                       input logic c, input logic s);
    in_valid  = 1'b1;
    in_opcode = op;
    in_result = data;
    in_rd     = rd;
    in_wen    = wen;
    in_carry  = c;
    in_shift  = s;
  endtask

  // Present one entry for exactly one cycle.
  task automatic push(input logic [3:0] op, input logic [7:0] data,
                      input logic [RADDR_W-1:0] rd, input logic wen,
                      input logic c, input logic s);
    drive(op, data, rd, wen, c, s);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_count",    count,     0);
    check("rst_valid",    out_valid, 0);
    check("rst_data",     out_data,  0);
    check("rst_rd",       out_rd,    0);
    check("rst_wen",      out_wen,   0);
    check("rst_carry",    carry_q,   0);
    check("rst_shift",    shift_q,   0);
    check("rst_in_ready", in_ready,  1);

    // Single ADD with latency 1, drained the following cycle
    out_ready = 1'b1;
    push(ADD, 8'h10, 3'd3, 1'b1, 1'b0, 1'b0);
    check("lat_valid", out_valid, 1);
    check("lat_data",  out_data,  8'h10);
    check("lat_rd",    out_rd,    3);
    check("lat_wen",   out_wen,   1);
    check("lat_count", count,     1);
    tick();
    check("drain_count", count,     0);
    check("drain_valid", out_valid, 0);

    // Flag selectivity
    push(ADD, 8'h01, 3'd1, 1'b1, 1'b1, 1'b0);
    check("add_carry", carry_q, 1);
    check("add_shift", shift_q, 0);
    push(AND_, 8'h02, 3'd2, 1'b1, 1'b0, 1'b1);
    check("and_carry", carry_q, 1);
    check("and_shift", shift_q, 0);
    push(SHL, 8'h04, 3'd4, 1'b1, 1'b0, 1'b1);
    check("shl_carry", carry_q, 1);
    check("shl_shift", shift_q, 1);
    push(SUB, 8'h05, 3'd5, 1'b0, 1'b0, 1'b0);
    check("sub_carry", carry_q, 0);
    check("sub_shift", shift_q, 1);
    check("stream_count", count, 1);
    check("stream_wen",   out_wen, 0);
    tick();
    check("stream_empty", count, 0);

    // Backpressure: fill, refuse a third, then drain in order
    out_ready = 1'b0;
    push(OR_, 8'hA1, 3'd1, 1'b1, 1'b0, 1'b0);
    push(OR_, 8'hA2, 3'd2, 1'b1, 1'b0, 1'b0);
    check("bp_count",    count,    2);
    check("bp_in_ready", in_ready, 0);
    check("bp_head",     out_data, 8'hA1);
    push(OR_, 8'hA3, 3'd3, 1'b1, 1'b0, 1'b0);
    check("bp_refuse_count", count,    2);
    check("bp_refuse_head",  out_data, 8'hA1);
    out_ready = 1'b1;
    #1;
    check("bp_pop1_data", out_data, 8'hA1);
    check("bp_pop1_rd",   out_rd,   1);
    tick();
    check("bp_pop2_data", out_data, 8'hA2);
    check("bp_pop2_rd",   out_rd,   2);
    check("bp_pop2_count", count,   1);
    tick();
    check("bp_empty", count, 0);

    // Full with simultaneous pop: input held off one cycle, then accepted
    out_ready = 1'b0;
    push(NOP, 8'hB1, 3'd1, 1'b1, 1'b0, 1'b0);
    push(NOP, 8'hB2, 3'd2, 1'b0, 1'b0, 1'b0);
    drive(OR_, 8'hB3, 3'd3, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    check("fp_in_ready_full", in_ready, 0);
    tick();
    check("fp_count1",      count,    1);
    check("fp_head_b2",     out_data, 8'hB2);
    check("fp_nop_wen",     out_wen,  0);
    check("fp_in_ready_ok", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("fp_count_same", count,    1);
    check("fp_head_b3",    out_data, 8'hB3);
    tick();
    check("fp_empty", count, 0);

    // Flush mid-stream
    out_ready = 1'b0;
    push(ADD, 8'hC1, 3'd1, 1'b1, 1'b1, 1'b0);
    push(AND_, 8'hC2, 3'd2, 1'b1, 1'b0, 1'b0);
    check("fl_pre_count", count,   2);
    check("fl_pre_carry", carry_q, 1);
    drive(SUB, 8'hC3, 3'd3, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_count", count,     0);
    check("fl_valid", out_valid, 0);
    check("fl_carry", carry_q,   1);
    tick();
    check("fl_not_consumed", count, 0);
    push(SHL, 8'hD1, 3'd6, 1'b1, 1'b0, 1'b1);
    check("fl_restart_data", out_data, 8'hD1);
    check("fl_restart_rd",   out_rd,   6);
    check("fl_restart_shift", shift_q, 1);

    // Reset together with flush and a push clears everything
    drive(ADD, 8'hE1, 3'd7, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rf_count", count,     0);
    check("rf_valid", out_valid, 0);
    check("rf_data",  out_data,  0);
    check("rf_rd",    out_rd,    0);
    check("rf_wen",   out_wen,   0);
    check("rf_carry", carry_q,   0);
    check("rf_shift", shift_q,   0);

`ifdef ALU_WB_ZERO_FLAG_EN
    // Zero flag
    out_ready = 1'b1;
    check("z_reset", zero_q, 0);
    push(SUB, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);
    check("z_sub_zero", zero_q, 1);
    push(OR_, 8'h05, 3'd2, 1'b1, 1'b0, 1'b0);
    check("z_or_nonzero", zero_q, 0);
    push(NOP, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
    check("z_nop_hold", zero_q, 0);
    push(SUB, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("z_flush_hold", zero_q, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
